pong_pixel_gen: RTL and testbench
=================================

PONG_PIXEL_GEN -- requirements
Module: pong_pixel_gen

Interface
REQ-001 The block SHALL have parameter PAD_H, default 72, meaning paddle height in lines.
REQ-002 The block SHALL have parameter PAD_VEL, default 3, meaning paddle step in lines per frame.
REQ-003 The block SHALL have parameter BALL_VEL, default 2, meaning ball step per axis in pixels per frame.
REQ-004 The block SHALL have parameter SERVE_FRAMES, default 60, meaning frames the ball is held at centre before play.
REQ-005 The block SHALL have port clk_100Mhz, input, 1 bit, meaning the system clock; one clock, with all state in this domain.
REQ-006 The block SHALL have port reset_n, input, 1 bit, meaning asynchronous active-low reset.
REQ-007 The block SHALL have port p_tick, input, 1 bit, meaning the pixel strobe from the timing stage (1 cycle in 4).
REQ-008 The block SHALL have ports x and y, input, 10 bits each, meaning the current pixel column and line.
REQ-009 The block SHALL have port video_on, input, 1 bit, meaning active display area.
REQ-010 The block SHALL have ports btn_up and btn_down, input, 1 bit each, meaning synchronous paddle controls.
REQ-011 The block SHALL have port rgb, output, 12 bits, meaning pixel colour {R4,G4,B4}.
REQ-012 The block SHALL have port score, output, 4 bits, meaning the miss count.

Function
REQ-013 The frame tick SHALL be a single-cycle pulse: p_tick=1 and x=0 and y=481.
REQ-014 Object geometry SHALL be as follows.
- Wall: x 32..39, all lines.
- Paddle: x 600..603, y from pad_y to pad_y+PAD_H-1.
- Ball: 8x8 square at (ball_x, ball_y), top-left corner.
REQ-015 rgb SHALL be registered and SHALL update only on cycles with p_tick=1.
- Colour is computed from the same-cycle x, y and video_on.
- Latency is one clk_100Mhz cycle.
- rgb holds its value otherwise.
REQ-016 Colour priority SHALL be ball 12'hF00 > paddle 12'h0F0 > wall 12'h00F > background 12'h000; video_on=0 forces 12'h000.
REQ-017 Paddle motion SHALL take effect on the frame tick only.
- btn_up alone: pad_y decreases by PAD_VEL, clamped at 0 with no underflow.
- btn_down alone: pad_y increases by PAD_VEL, clamped at 480-PAD_H.
- Both buttons or neither: no move.
REQ-018 The FSM SHALL have states SERVE, PLAY and MISS.
- SERVE: ball fixed at (316,236); a frame counter counts SERVE_FRAMES ticks, then the FSM goes to PLAY with vx=+BALL_VEL and vy=+BALL_VEL.
- PLAY: on each tick, ball position advances by (vx,vy) after the bounce evaluation below.
- MISS: lasts exactly one frame tick, increments score, then returns to SERVE.
REQ-019 Bounce evaluation SHALL be done on the pre-move position, with every rule evaluated independently in the same tick.
- ball_y <= BALL_VEL: vy set to +.
- ball_y+7 >= 479-BALL_VEL: vy set to -.
- ball_x <= 40: vx set to +.
- Paddle hit: vx>0, ball_x+7 in 600..603, and the ball's y-span overlapping the paddle: vx set to -.
REQ-020 Simultaneous bounce events (corner hits) SHALL flip both velocity signs in the same tick.
REQ-021 The FSM SHALL move from PLAY to MISS on a tick where ball_x+7 > 639; the ball is not moved on that tick.
REQ-022 score SHALL wrap from 15 to 0.
REQ-023 All position arithmetic SHALL be 10-bit unsigned, and velocities SHALL be stored as a sign bit plus magnitude.

Reset
REQ-024 Asserting reset_n=0 at any time, including mid-PLAY, SHALL immediately set the following.
- rgb=0 and score=0.
- FSM=SERVE with serve counter 0.
- pad_y=204 and ball at (316,236).
- vx and vy positive.
REQ-025 Operation SHALL resume on the first clk_100Mhz edge after release.

Configuration
REQ-026 When macro PONG_SCORE_EN is defined, score SHALL count misses as in REQ-018 and REQ-022.
REQ-027 When macro PONG_SCORE_EN is undefined, score SHALL be constant 0, no counter register SHALL exist, and MISS SHALL still last one frame.

Structure
REQ-028 A shared package pong_pkg SHALL hold the following.
- Screen constants (640, 480, frame-tick line 481).
- Wall and paddle x-bounds.
- Ball size 8.
- Colour constants.
- The FSM state enum.
REQ-029 The paddle position and clamp logic SHALL be the single sub-module pong_paddle_ctrl, with inputs tick, btn_up and btn_down and output pad_y.

Verification
REQ-030 The bench SHALL cover reset and serve: release reset_n, run 60 frame ticks -> FSM=PLAY on tick 60 and ball at (318,238) after tick 61.
REQ-031 The bench SHALL cover the paddle clamp: hold btn_up for 80 frames -> pad_y reaches 0 and stays 0; hold btn_down for 200 frames -> pad_y=408; both buttons held -> pad_y unchanged.
REQ-032 The bench SHALL cover a paddle hit: pad_y=200, ball reaches ball_x+7=601 at ball_y=230 moving right -> vx negative on that tick, and no MISS.
REQ-033 The bench SHALL cover a miss: pad_y=0, ball at y=300 moving right -> MISS for one tick, score 0->1, then SERVE with ball at (316,236).
REQ-034 The bench SHALL cover colour output: x=320, y=240 with the ball at (316,236) and p_tick=1 -> rgb=12'hF00 one cycle later; same pixel with video_on=0 -> rgb=12'h000.
REQ-035 The bench SHALL cover reset mid-play: assert reset_n=0 during PLAY -> all REQ-024 values hold within the same cycle, without waiting for a clock edge.

Source files
------------

// File: rtl/pong_pkg.sv
// +--------------------------------------------------------------------+
// | pong_pkg: screen geometry, colours and FSM state type for pong.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package pong_pkg;

  localparam logic [9:0] H_RES      = 10'd640;
  localparam logic [9:0] V_RES      = 10'd480;
  localparam logic [9:0] H_MAX      = H_RES - 10'd1;
  localparam logic [9:0] V_MAX      = V_RES - 10'd1;
  localparam logic [9:0] FRAME_LINE = 10'd481;

  localparam logic [9:0] WALL_X_L      = 10'd32;
  localparam logic [9:0] WALL_X_R      = 10'd39;
  localparam logic [9:0] WALL_BOUNCE_X = 10'd40;
  localparam logic [9:0] PAD_X_L       = 10'd600;
  localparam logic [9:0] PAD_X_R       = 10'd603;
  localparam logic [9:0] BALL_SIZE     = 10'd8;

  localparam logic [9:0] BALL_X0 = 10'd316;
  localparam logic [9:0] BALL_Y0 = 10'd236;
  localparam logic [9:0] PAD_Y0  = 10'd204;

  localparam logic [11:0] RGB_BALL = 12'hF00;
  localparam logic [11:0] RGB_PAD  = 12'h0F0;
  localparam logic [11:0] RGB_WALL = 12'h00F;
  localparam logic [11:0] RGB_BG   = 12'h000;

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    MISS  = 2'd2
  } pong_state_e;

  function automatic logic in_span(input logic [9:0] v, input logic [9:0] lo,
                                   input logic [9:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pong_paddle_ctrl.sv
// +--------------------------------------------------------------------+
// | pong_paddle_ctrl: paddle line position, stepped once per frame     |
// | tick and clamped to the visible area.  Revision: 1.0               |
// +--------------------------------------------------------------------+
`default_nettype none

module pong_paddle_ctrl
  import pong_pkg::*;
#(
  parameter int PAD_H   = 72,
  parameter int PAD_VEL = 3
) (
  input  logic       clk_100Mhz,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [9:0] pad_y
);

  localparam logic [9:0] PAD_Y_MAX = V_RES - 10'(PAD_H);
  localparam logic [9:0] STEP      = 10'(PAD_VEL);

  logic [9:0] r_pad_y;

  // Compare before subtracting/adding so the 10-bit value never wraps.
  always_ff @(posedge clk_100Mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_pad_y <= PAD_Y0;
    end else if (tick && btn_up && !btn_down) begin
      r_pad_y <= (r_pad_y < STEP) ? 10'd0 : r_pad_y - STEP;
    end else if (tick && btn_down && !btn_up) begin
      r_pad_y <= (r_pad_y > PAD_Y_MAX - STEP) ? PAD_Y_MAX : r_pad_y + STEP;
    end
  end

  assign pad_y = r_pad_y;

endmodule

`default_nettype wire

// File: rtl/pong_pixel_gen.sv
// +--------------------------------------------------------------------+
// | pong_pixel_gen: pong game state and registered pixel colour.       |
// | Optional macro PONG_SCORE_EN enables the miss counter on score.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module pong_pixel_gen
  import pong_pkg::*;
#(
  parameter int PAD_H        = 72,
  parameter int PAD_VEL      = 3,
  parameter int BALL_VEL     = 2,
  parameter int SERVE_FRAMES = 60
) (
  input  logic        clk_100Mhz,
  input  logic        reset_n,
  input  logic        p_tick,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        video_on,
  input  logic        btn_up,
  input  logic        btn_down,
  output logic [11:0] rgb,
  output logic [3:0]  score
);

  localparam int               CNT_W      = $clog2(SERVE_FRAMES + 1);
  localparam logic [9:0]       BVEL       = 10'(BALL_VEL);
  localparam logic [9:0]       PAD_SPAN   = 10'(PAD_H - 1);
  localparam logic [9:0]       BALL_LAST  = BALL_SIZE - 10'd1;
  localparam logic [9:0]       BOTTOM_LIM = V_MAX - BVEL;
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);

  pong_state_e      r_state;
  logic [CNT_W-1:0] r_serve_cnt;
  logic [9:0]       r_ball_x, r_ball_y;
  logic             r_vx_neg, r_vy_neg;
  logic [11:0]      r_rgb;

  logic       w_frame_tick;
  logic [9:0] w_pad_y, w_pad_b, w_ball_r, w_ball_b;
  logic       w_hit_top, w_hit_bot, w_hit_wall, w_hit_pad, w_out;
  logic       w_vx_neg_nxt, w_vy_neg_nxt;
  logic [9:0] w_ball_x_nxt, w_ball_y_nxt;
  logic       w_in_ball, w_in_pad, w_in_wall;
  logic [11:0] w_rgb_nxt;

  assign w_frame_tick = p_tick && (x == 10'd0) && (y == FRAME_LINE);

  pong_paddle_ctrl #(
    .PAD_H   (PAD_H),
    .PAD_VEL (PAD_VEL)
  ) u_paddle (
    .clk_100Mhz (clk_100Mhz),
    .reset_n    (reset_n),
    .tick       (w_frame_tick),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .pad_y      (w_pad_y)
  );

  assign w_pad_b  = w_pad_y + PAD_SPAN;
  assign w_ball_r = r_ball_x + BALL_LAST;
  assign w_ball_b = r_ball_y + BALL_LAST;

  assign w_hit_top  = r_ball_y <= BVEL;
  assign w_hit_bot  = w_ball_b >= BOTTOM_LIM;
  assign w_hit_wall = r_ball_x <= WALL_BOUNCE_X;
  assign w_hit_pad  = !r_vx_neg && in_span(w_ball_r, PAD_X_L, PAD_X_R) &&
                      (r_ball_y <= w_pad_b) && (w_ball_b >= w_pad_y);
  assign w_out      = w_ball_r > H_MAX;

  // Bounces are judged on the pre-move position; the move uses the new signs.
  always_comb begin
    w_vx_neg_nxt = r_vx_neg;
    w_vy_neg_nxt = r_vy_neg;
    if (w_hit_top)  w_vy_neg_nxt = 1'b0;
    if (w_hit_bot)  w_vy_neg_nxt = 1'b1;
    if (w_hit_wall) w_vx_neg_nxt = 1'b0;
    if (w_hit_pad)  w_vx_neg_nxt = 1'b1;
    w_ball_x_nxt = w_vx_neg_nxt ? r_ball_x - BVEL : r_ball_x + BVEL;
    w_ball_y_nxt = w_vy_neg_nxt ? r_ball_y - BVEL : r_ball_y + BVEL;
  end

  always_ff @(posedge clk_100Mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= SERVE;
      r_serve_cnt <= '0;
      r_ball_x    <= BALL_X0;
      r_ball_y    <= BALL_Y0;
      r_vx_neg    <= 1'b0;
      r_vy_neg    <= 1'b0;
    end else if (w_frame_tick) begin
      case (r_state)
        SERVE: begin
          if (r_serve_cnt == SERVE_LAST) begin
            r_state     <= PLAY;
            r_serve_cnt <= '0;
            r_vx_neg    <= 1'b0;
            r_vy_neg    <= 1'b0;
          end else begin
            r_serve_cnt <= r_serve_cnt + 1'b1;
          end
        end
        PLAY: begin
          if (w_out) begin
            r_state <= MISS;
          end else begin
            r_vx_neg <= w_vx_neg_nxt;
            r_vy_neg <= w_vy_neg_nxt;
            r_ball_x <= w_ball_x_nxt;
            r_ball_y <= w_ball_y_nxt;
          end
        end
        MISS: begin
          r_state     <= SERVE;
          r_serve_cnt <= '0;
          r_ball_x    <= BALL_X0;
          r_ball_y    <= BALL_Y0;
          r_vx_neg    <= 1'b0;
          r_vy_neg    <= 1'b0;
        end
        default: r_state <= SERVE;
      endcase
    end
  end

`ifdef PONG_SCORE_EN
  logic [3:0] r_score;

  always_ff @(posedge clk_100Mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_score <= 4'd0;
    end else if (w_frame_tick && (r_state == MISS)) begin
      r_score <= r_score + 4'd1;
    end
  end

  assign score = r_score;
`else
  assign score = 4'd0;
`endif

  assign w_in_ball = in_span(x, r_ball_x, w_ball_r) && in_span(y, r_ball_y, w_ball_b);
  assign w_in_pad  = in_span(x, PAD_X_L, PAD_X_R) && in_span(y, w_pad_y, w_pad_b);
  assign w_in_wall = in_span(x, WALL_X_L, WALL_X_R);

  always_comb begin
    w_rgb_nxt = RGB_BG;
    if (video_on) begin
      if (w_in_ball)      w_rgb_nxt = RGB_BALL;
      else if (w_in_pad)  w_rgb_nxt = RGB_PAD;
      else if (w_in_wall) w_rgb_nxt = RGB_WALL;
    end
  end

  always_ff @(posedge clk_100Mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_rgb <= RGB_BG;
    end else if (p_tick) begin
      r_rgb <= w_rgb_nxt;
    end
  end

  assign rgb = r_rgb;

endmodule

`default_nettype wire

// File: tb/tb_pong_pixel_gen.sv
// +--------------------------------------------------------------------+
// | tb_pong_pixel_gen: directed self-checking bench for pong_pixel_gen.|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_pong_pixel_gen;
  import pong_pkg::*;

`ifdef PONG_SCORE_EN
  localparam logic [15:0] EXP_SCORE = 16'd1;
`else
  localparam logic [15:0] EXP_SCORE = 16'd0;
`endif

  logic        clk_100Mhz = 1'b0;
  logic        reset_n;
  logic        p_tick;
  logic [9:0]  x, y;
  logic        video_on;
  logic        btn_up, btn_down;
  logic [11:0] rgb;
  logic [3:0]  score;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_100Mhz = ~clk_100Mhz;

  pong_pixel_gen dut (
    .clk_100Mhz (clk_100Mhz),
    .reset_n    (reset_n),
    .p_tick     (p_tick),
    .x          (x),
    .y          (y),
    .video_on   (video_on),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .rgb        (rgb),
    .score      (score)
  );

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_100Mhz);
      p_tick = 1'b1; x = 10'd0; y = FRAME_LINE; video_on = 1'b0;
      @(negedge clk_100Mhz);
      p_tick = 1'b0; x = 10'd5; y = 10'd5;
    end
  endtask

  task automatic pixel(input logic [9:0] px, input logic [9:0] py, input logic von);
    @(negedge clk_100Mhz);
    p_tick = 1'b1; x = px; y = py; video_on = von;
    @(negedge clk_100Mhz);
    p_tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_100Mhz);
    reset_n = 1'b0;
    @(negedge clk_100Mhz);
    reset_n = 1'b1;
  endtask

  task automatic chk_ball(input string tag, input logic [9:0] ex, input logic [9:0] ey);
    chk({tag, "_x"}, 16'(dut.r_ball_x), 16'(ex));
    chk({tag, "_y"}, 16'(dut.r_ball_y), 16'(ey));
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_rgb"},   16'(rgb), 16'h000);
    chk({tag, "_score"}, 16'(score), 16'd0);
    chk({tag, "_state"}, 16'(dut.r_state), 16'(SERVE));
    chk({tag, "_cnt"},   16'(dut.r_serve_cnt), 16'd0);
    chk({tag, "_pad"},   16'(dut.w_pad_y), 16'd204);
    chk_ball(tag, 10'd316, 10'd236);
    chk({tag, "_vxneg"}, 16'(dut.r_vx_neg), 16'd0);
    chk({tag, "_vyneg"}, 16'(dut.r_vy_neg), 16'd0);
  endtask

  // Pixel vectors with the ball at (316,236) and the paddle at 204..275.
  localparam int NPIX = 17;
  logic [9:0]  pv_x   [NPIX] = '{10'd320, 10'd320, 10'd316, 10'd323, 10'd324, 10'd323,
                                  10'd601, 10'd600, 10'd603, 10'd604, 10'd601, 10'd601,
                                  10'd32,  10'd39,  10'd40,  10'd31,  10'd320};
  logic [9:0]  pv_y   [NPIX] = '{10'd240, 10'd240, 10'd236, 10'd243, 10'd243, 10'd244,
                                  10'd210, 10'd204, 10'd275, 10'd275, 10'd276, 10'd203,
                                  10'd100, 10'd479, 10'd100, 10'd100, 10'd240};
  logic        pv_von [NPIX] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [11:0] pv_rgb [NPIX] = '{12'hF00, 12'h000, 12'hF00, 12'hF00, 12'h000, 12'h000,
                                  12'h0F0, 12'h0F0, 12'h0F0, 12'h000, 12'h000, 12'h000,
                                  12'h00F, 12'h00F, 12'h000, 12'h000, 12'hF00};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; p_tick = 1'b0; x = 10'd0; y = 10'd0;
    video_on = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    repeat (3) @(negedge clk_100Mhz);
    reset_n = 1'b1;
    @(negedge clk_100Mhz);
    chk_reset_values("rst");

    for (int i = 0; i < NPIX; i++) begin
      pixel(pv_x[i], pv_y[i], pv_von[i]);
      chk($sformatf("pix%0d", i), 16'(rgb), 16'(pv_rgb[i]));
    end
    @(negedge clk_100Mhz);
    x = 10'd100; y = 10'd100; video_on = 1'b1;
    @(negedge clk_100Mhz);
    chk("rgb_hold", 16'(rgb), 16'hF00);

    // Serve phase
    run_ticks(59);
    chk("serve59_state", 16'(dut.r_state), 16'(SERVE));
    chk("serve59_cnt", 16'(dut.r_serve_cnt), 16'd59);
    run_ticks(1);
    chk("serve60_state", 16'(dut.r_state), 16'(PLAY));
    chk_ball("serve60", 10'd316, 10'd236);
    run_ticks(1);
    chk_ball("play1", 10'd318, 10'd238);

    // Paddle clamp
    btn_up = 1'b1;
    run_ticks(67);
    chk("pad_up67", 16'(dut.w_pad_y), 16'd3);
    run_ticks(1);
    chk("pad_up68", 16'(dut.w_pad_y), 16'd0);
    run_ticks(12);
    chk("pad_up80", 16'(dut.w_pad_y), 16'd0);
    btn_up = 1'b0; btn_down = 1'b1;
    run_ticks(135);
    chk("pad_dn135", 16'(dut.w_pad_y), 16'd405);
    run_ticks(65);
    chk("pad_dn200", 16'(dut.w_pad_y), 16'd408);
    btn_up = 1'b1;
    run_ticks(5);
    chk("pad_both", 16'(dut.w_pad_y), 16'd408);
    btn_down = 1'b0;
    run_ticks(1);
    chk("pad_up1", 16'(dut.w_pad_y), 16'd405);
    btn_up = 1'b0;
    run_ticks(3);
    chk("pad_none", 16'(dut.w_pad_y), 16'd405);

    // Paddle hit: first arrival at the paddle is (594,426) with pad_y=408
    do_reset();
    btn_down = 1'b1;
    run_ticks(60 + 139);
    chk("hit_pre_state", 16'(dut.r_state), 16'(PLAY));
    chk("hit_pre_pad", 16'(dut.w_pad_y), 16'd408);
    chk_ball("hit_pre", 10'd594, 10'd426);
    chk("hit_pre_vxneg", 16'(dut.r_vx_neg), 16'd0);
    chk("hit_pre_vyneg", 16'(dut.r_vy_neg), 16'd1);
    run_ticks(1);
    chk("hit_vxneg", 16'(dut.r_vx_neg), 16'd1);
    chk("hit_state", 16'(dut.r_state), 16'(PLAY));
    chk_ball("hit", 10'd592, 10'd424);
    run_ticks(1);
    chk_ball("hit_next", 10'd590, 10'd422);
    btn_down = 1'b0;

    // Miss: paddle parked at 0, ball leaves at (634,386)
    do_reset();
    btn_up = 1'b1;
    run_ticks(60 + 159);
    chk("miss_pre_state", 16'(dut.r_state), 16'(PLAY));
    chk_ball("miss_pre", 10'd634, 10'd386);
    chk("miss_pre_score", 16'(score), 16'd0);
    run_ticks(1);
    chk("miss_state", 16'(dut.r_state), 16'(MISS));
    chk_ball("miss", 10'd634, 10'd386);
    run_ticks(1);
    chk("miss_exit_state", 16'(dut.r_state), 16'(SERVE));
    chk("miss_exit_score", 16'(score), EXP_SCORE);
    chk("miss_exit_cnt", 16'(dut.r_serve_cnt), 16'd0);
    chk_ball("miss_exit", 10'd316, 10'd236);
    btn_up = 1'b0;

    // Reset in the middle of play
    run_ticks(60 + 5);
    chk("mid_state", 16'(dut.r_state), 16'(PLAY));
    chk_ball("mid", 10'd326, 10'd246);
    pixel(10'd601, 10'd10, 1'b1);
    chk("mid_rgb_pad", 16'(rgb), 16'h0F0);
    @(negedge clk_100Mhz);
    #2 reset_n = 1'b0;
    #1 chk_reset_values("async");
    @(negedge clk_100Mhz);
    reset_n = 1'b1;
    run_ticks(1);
    chk("resume_cnt", 16'(dut.r_serve_cnt), 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
